i2s_rx: RTL and testbench



---
 rtl/i2s_rx_pkg.sv | 32 +++
 rtl/i2s_rx_sync_edge_det.sv | 37 +++
 rtl/i2s_rx.sv | 218 +++++++++++++++++++++
 tb/tb_i2s_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the WM8731 ADC serial receiver: FSM encoding,
// serial format selectors and the sample width used across the audio path.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package i2s_rx_pkg;

    // Sample width shared with the downstream FIR filters and bypass select.
    localparam int DATA_WIDTH = `DATA_WIDTH;

    // Serial format selectors for the I2S_MODE parameter.
    localparam bit FMT_I2S = 1'b1;  // MSB one BCLK after the LRCK edge
    localparam bit FMT_LJ  = 1'b0;  // MSB on the BCLK at the LRCK edge

    // Channel encoding follows ADCLRCK: low = left, high = right.
    localparam bit CH_LEFT  = 1'b0;
    localparam bit CH_RIGHT = 1'b1;

    // Receiver FSM.
    //   ST_IDLE  : waiting for the first left-channel LRCK edge
    //   ST_DELAY : skipping the single padding bit of I2S framing
    //   ST_SHIFT : shifting in data bits MSB first
    //   ST_DRAIN : word complete, ignoring LSB padding until the next edge
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DRAIN = 2'd3
    } rx_state_e;

endpackage

// File: rtl/i2s_rx_sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous level plus single-cycle
// rise/fall pulses derived from the synchronised value.
// SYNC_STAGES must be at least 2.
module i2s_rx_sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser and remember the last
    // synchronised level for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= level;
        end
    end

    // Edge pulses are combinational so they line up with the synchronised
    // data lines that went through the same number of flops.
    assign rise_o = level & ~prev_q;
    assign fall_o = ~level & prev_q;

endmodule

// File: rtl/i2s_rx.sv
// WM8731 ADC serial receiver (codec in slave mode). Oversamples BCLK,
// ADCLRCK and ADCDAT on clk_i, deserialises one stereo frame at a time and
// presents a registered left/right pair with a one-cycle valid strobe.
//
// Capture happens only on synchronised BCLK rising edges; LRCK and DAT are
// synchronised with the same depth as BCLK so the three stay aligned.
// left_o/right_o only change together with valid_o, so a right word without a
// committed left word of the same frame is dropped and the outputs hold.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = i2s_rx_pkg::DATA_WIDTH,
    parameter bit I2S_MODE    = FMT_I2S,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  bclk_i,
    input  logic                  lrck_i,
    input  logic                  dat_i,
    output logic [DATA_WIDTH-1:0] left_o,
    output logic [DATA_WIDTH-1:0] right_o,
    output logic                  valid_o,
    output logic                  short_o
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic bclk_rise;
    logic bclk_fall_unused;

    i2s_rx_sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bclk_det (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (bclk_i),
        .rise_o (bclk_rise),
        .fall_o (bclk_fall_unused)
    );

    logic [SYNC_STAGES-1:0] lrck_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   lrck_s;
    logic                   dat_s;

    // Plain synchronisers for LRCK and DAT, same depth as the BCLK path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lrck_sync_q <= '0;
            dat_sync_q  <= '0;
        end else begin
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], lrck_i};
            dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], dat_i};
        end
    end

    assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
    assign dat_s  = dat_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Deserialiser state
    // ------------------------------------------------------------------
    rx_state_e             state_q,   state_d;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q,   shreg_d;
    logic                  chan_q,    chan_d;
    logic [DATA_WIDTH-1:0] hold_q,    hold_d;
    logic                  hold_ok_q, hold_ok_d;
    logic                  lrck_prev_q, lrck_prev_d;
    logic [DATA_WIDTH-1:0] left_q,    left_d;
    logic [DATA_WIDTH-1:0] right_q,   right_d;
    logic                  valid_q,   valid_d;
    logic                  short_q,   short_d;

    logic                  lrck_edge;
    logic                  start_word;
    logic [DATA_WIDTH-1:0] shifted;

    // LRCK as seen at this rise versus the previous rise.
    assign lrck_edge = (lrck_s != lrck_prev_q);
    assign shifted   = {shreg_q[DATA_WIDTH-2:0], dat_s};

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            chan_q      <= CH_LEFT;
            hold_q      <= '0;
            hold_ok_q   <= 1'b0;
            lrck_prev_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            chan_q      <= chan_d;
            hold_q      <= hold_d;
            hold_ok_q   <= hold_ok_d;
            lrck_prev_q <= lrck_prev_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            short_q     <= short_d;
        end
    end

    // Next-state, capture and commit logic; everything advances on BCLK rise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        chan_d      = chan_q;
        hold_d      = hold_q;
        hold_ok_d   = hold_ok_q;
        lrck_prev_d = lrck_prev_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        short_d     = 1'b0;
        start_word  = 1'b0;

        if (bclk_rise) begin
            lrck_prev_d = lrck_s;

            unique case (state_q)
                ST_IDLE: begin
                    // Only a falling LRCK marks a frame start we can trust.
                    if (lrck_edge && (lrck_s == CH_LEFT)) begin
                        start_word = 1'b1;
                    end
                end

                ST_DELAY: begin
                    // The edge bit was the skipped slot; this one is the MSB.
                    shreg_d = shifted;
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (lrck_edge && (cnt_q != LAST_CNT)) begin
                        // Truncated word: drop it and resync on the new channel.
                        short_d    = 1'b1;
                        start_word = 1'b1;
                        if (chan_q == CH_LEFT) begin
                            hold_ok_d = 1'b0;
                        end
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            cnt_d   = '0;
                            state_d = ST_DRAIN;
                            if (chan_q == CH_LEFT) begin
                                hold_d    = shifted;
                                hold_ok_d = 1'b1;
                            end else begin
                                if (hold_ok_q) begin
                                    left_d  = hold_q;
                                    right_d = shifted;
                                    valid_d = 1'b1;
                                end
                                hold_ok_d = 1'b0;
                            end
                            // Word exactly filled the half frame: the edge that
                            // ends it also starts the next channel.
                            if (lrck_edge) begin
                                start_word = 1'b1;
                            end
                        end
                    end
                end

                ST_DRAIN: begin
                    if (lrck_edge) begin
                        start_word = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Begin a new channel word selected by the current LRCK level.
            if (start_word) begin
                chan_d = lrck_s;
                if (lrck_s == CH_LEFT) begin
                    hold_ok_d = 1'b0;
                end
                if (I2S_MODE == FMT_I2S) begin
                    cnt_d   = '0;
                    state_d = ST_DELAY;
                end else begin
                    shreg_d = shifted;
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
        end
    end

    assign left_o  = left_q;
    assign right_o = right_q;
    assign valid_o = valid_q;
    assign short_o = short_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx. Two receivers, one per serial format, listen to
// the same codec lines so every stimulus frame checks both alignments.
module tb_i2s_rx;

    localparam int DW    = 16;
    localparam int W     = 2 * DW;
    localparam int NRAND = 40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bclk = 1'b0;
    logic lrck = 1'b0;
    logic dat  = 1'b0;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] left_i2s, right_i2s, left_lj, right_lj;
    logic          valid_i2s, short_i2s, valid_lj, short_lj;

    i2s_rx #(.DATA_WIDTH(DW), .I2S_MODE(1'b1), .SYNC_STAGES(2)) u_dut_i2s (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bclk_i  (bclk),
        .lrck_i  (lrck),
        .dat_i   (dat),
        .left_o  (left_i2s),
        .right_o (right_i2s),
        .valid_o (valid_i2s),
        .short_o (short_i2s)
    );

    i2s_rx #(.DATA_WIDTH(DW), .I2S_MODE(1'b0), .SYNC_STAGES(2)) u_dut_lj (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bclk_i  (bclk),
        .lrck_i  (lrck),
        .dat_i   (dat),
        .left_o  (left_lj),
        .right_o (right_lj),
        .valid_o (valid_lj),
        .short_o (short_lj)
    );

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;
    logic [W-1:0] exp_q_i2s[$];
    logic [W-1:0] exp_q_lj[$];
    int n_valid_i2s = 0, n_valid_lj = 0;
    int n_short_i2s = 0, n_short_lj = 0;
    int last_valid_cyc_i2s = 0, last_valid_cyc_lj = 0;
    int mark_cyc = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word as seen by a receiver of format dut_i2s when the codec sends
    // stim_i2s framing with zero padding around the word.
    function automatic logic [DW-1:0] rx_word(input logic [DW-1:0] w, input bit stim_i2s, input bit dut_i2s);
        if (stim_i2s == dut_i2s) return w;
        if (stim_i2s) return w >> 1;  // LJ receiver grabs padding slot + 15 MSBs
        return w << 1;                 // I2S receiver misses MSB, gets a 0 pad
    endfunction

    task automatic push_exp(input logic [W-1:0] e_i2s, input logic [W-1:0] e_lj);
        exp_q_i2s.push_back(e_i2s);
        exp_q_lj.push_back(e_lj);
    endtask

    // Monitor sampling on the falling clock edge.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (valid_i2s) begin
            n_valid_i2s++;
            last_valid_cyc_i2s = cyc;
            if (exp_q_i2s.size() == 0) begin
                check("i2s_unexpected_valid", 1, 0);
            end else begin
                e = exp_q_i2s.pop_front();
                check("i2s_left", W'(left_i2s), W'(e[W-1:DW]));
                check("i2s_right", W'(right_i2s), W'(e[DW-1:0]));
            end
        end
        if (valid_lj) begin
            n_valid_lj++;
            last_valid_cyc_lj = cyc;
            if (exp_q_lj.size() == 0) begin
                check("lj_unexpected_valid", 1, 0);
            end else begin
                e = exp_q_lj.pop_front();
                check("lj_left", W'(left_lj), W'(e[W-1:DW]));
                check("lj_right", W'(right_lj), W'(e[DW-1:0]));
            end
        end
        if (short_i2s) n_short_i2s++;
        if (short_lj) n_short_lj++;
    end

    // ---------------- drivers ----------------
    // One BCLK period: data/LRCK change with the falling edge, codec-style.
    // Entry and exit are 1 time unit after a clk rising edge.
    task automatic send_bit(input logic l, input logic d, input int lo, input int hi, input bit mark);
        bclk = 1'b0;
        lrck = l;
        dat  = d;
        repeat (lo) @(posedge clk);
        #1;
        bclk = 1'b1;
        if (mark) mark_cyc = cyc;
        repeat (hi) @(posedge clk);
        #1;
    endtask

    // One stereo frame; lcut/rcut > 0 shorten a half to that many slots.
    task automatic send_frame(input logic [DW-1:0] lw, input logic [DW-1:0] rw, input bit stim_i2s,
                              input int half, input int lcut, input int rcut,
                              input int lo, input int hi, input bit jit);
        logic [DW-1:0] w;
        int n, idx, lo_j;
        logic d;
        for (int ch = 0; ch < 2; ch++) begin
            w = (ch == 0) ? lw : rw;
            n = half;
            if (ch == 0 && lcut > 0) n = lcut;
            if (ch == 1 && rcut > 0) n = rcut;
            for (int s = 0; s < n; s++) begin
                idx  = stim_i2s ? s - 1 : s;
                d    = (idx >= 0 && idx < DW) ? w[DW-1-idx] : 1'b0;
                lo_j = jit ? lo - 1 + int'($urandom_range(0, 2)) : lo;
                send_bit(logic'(ch == 1), d, lo_j, hi, (ch == 1 && idx == DW - 1));
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_left_i2s"},  W'(left_i2s),  0);
        check({tag, "_right_i2s"}, W'(right_i2s), 0);
        check({tag, "_valid_i2s"}, W'(valid_i2s), 0);
        check({tag, "_short_i2s"}, W'(short_i2s), 0);
        check({tag, "_left_lj"},   W'(left_lj),   0);
        check({tag, "_right_lj"},  W'(right_lj),  0);
        check({tag, "_valid_lj"},  W'(valid_lj),  0);
        check({tag, "_short_lj"},  W'(short_lj),  0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] rl, rr;

        // Reset
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LRCK high before the first frame so its fall is a real edge.
        repeat (2) send_bit(1'b1, 1'b0, 4, 4, 1'b0);

        // I2S-framed 1234/ABCD at clk = 8x BCLK, 32 slots per half.
        push_exp({16'h1234, 16'hABCD}, {16'h091A, 16'h55E6});
        send_frame(16'h1234, 16'hABCD, 1'b1, 32, 0, 0, 4, 4, 1'b0);
        check("lj_left_misaligned", W'(left_lj), W'(16'h091A));
        check("i2s_valid_count_f1", n_valid_i2s, 1);
        check("lj_valid_count_f1", n_valid_lj, 1);
        // 2 synchroniser flops, then the FSM registers valid one cycle later.
        check("i2s_valid_latency", last_valid_cyc_i2s - mark_cyc, 3);

        // Left-justified 1234/ABCD.
        push_exp({16'h2468, 16'h579A}, {16'h1234, 16'hABCD});
        send_frame(16'h1234, 16'hABCD, 1'b0, 32, 0, 0, 4, 4, 1'b0);
        check("lj_valid_latency", last_valid_cyc_lj - mark_cyc, 3);
        check("lj_right_f2", W'(right_lj), W'(16'hABCD));

        // Left word cut after 10 data bits, then a clean 7FFF/8000 frame.
        send_frame(16'hFFFF, 16'h1111, 1'b1, 32, 11, 0, 4, 4, 1'b0);
        check("i2s_short_count", n_short_i2s, 1);
        check("lj_short_count", n_short_lj, 1);
        check("i2s_no_valid_short_frame", n_valid_i2s, 2);
        check("lj_no_valid_short_frame", n_valid_lj, 2);
        push_exp({16'h7FFF, 16'h8000}, {16'h3FFF, 16'h4000});
        send_frame(16'h7FFF, 16'h8000, 1'b1, 32, 0, 0, 4, 4, 1'b0);

        // Reset in the middle of the right word of 5555/AAAA.
        send_frame(16'h5555, 16'hAAAA, 1'b1, 32, 0, 9, 4, 4, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("midreset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stream resumes with LRCK high mid right word; nothing until it falls.
        for (int i = 0; i < 10; i++) send_bit(1'b1, logic'($urandom_range(0, 1)), 4, 4, 1'b0);
        check("i2s_no_valid_before_left", n_valid_i2s, 3);
        push_exp({16'h1357, 16'h2468}, {16'h09AB, 16'h1234});
        send_frame(16'h1357, 16'h2468, 1'b1, 32, 0, 0, 4, 4, 1'b0);

        // Back-to-back random frames, clk ~ 5x BCLK with +-1 clk jitter.
        for (int f = 0; f < NRAND; f++) begin
            rl = DW'($urandom());
            rr = DW'($urandom());
            push_exp({rx_word(rl, 1'b1, 1'b1), rx_word(rr, 1'b1, 1'b1)},
                     {rx_word(rl, 1'b1, 1'b0), rx_word(rr, 1'b1, 1'b0)});
            send_frame(rl, rr, 1'b1, 20, 0, 0, 3, 2, 1'b1);
        end
        repeat (20) @(posedge clk);
        #1;

        // Final report
        check("i2s_total_valid", n_valid_i2s, 4 + NRAND);
        check("lj_total_valid", n_valid_lj, 4 + NRAND);
        check("i2s_exp_left_over", exp_q_i2s.size(), 0);
        check("lj_exp_left_over", exp_q_lj.size(), 0);
        check("i2s_short_total", n_short_i2s, 1);
        check("lj_short_total", n_short_lj, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
